// File: rtl/sdram_multiport_arbiter.sv
// Multi-port arbiter in front of an Avalon-MM SDRAM bridge.
// N_RD read ports and one write port (index N_RD) share a single master.
// Each transfer runs IDLE -> BUSY -> DONE. Grants use either fixed
// priority or round-robin. A wait counter in BUSY aborts a transfer that
// never receives avl_ack and raises a sticky timeout flag.
module sdram_multiport_arbiter #(
    parameter int N_RD    = 4,
    parameter int ADDR_W  = 26,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1023
) (
    input  logic                     MAX10_CLK1_50,
    input  logic                     Reset_h,
    input  logic                     mode_rr,
    input  logic                     write_override,
    input  logic [N_RD-1:0]          rd_req,
    input  logic [N_RD*ADDR_W-1:0]   rd_addr,
    output logic [N_RD-1:0]          rd_ack,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    output logic [ADDR_W-1:0]        avl_addr,
    output logic                     avl_read,
    output logic                     avl_write,
    output logic [DATA_W-1:0]        avl_wrdata,
    input  logic [DATA_W-1:0]        avl_rddata,
    input  logic                     avl_ack,
    output logic                     timeout_err
);
    localparam int NP = N_RD + 1;
    localparam int IW = $clog2(NP);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       winner_q, winner_d;
    logic [IW-1:0]       last_grant_q, last_grant_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   avl_addr_q, avl_addr_d;
    logic [DATA_W-1:0]   avl_wrdata_q, avl_wrdata_d;
    logic                avl_read_q, avl_read_d;
    logic                avl_write_q, avl_write_d;
    logic [N_RD-1:0]     rd_ack_q, rd_ack_d;
    logic                wr_ack_q, wr_ack_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                timeout_err_q, timeout_err_d;

    logic [NP-1:0]       elig_s;
    logic                grant_vld_s;
    logic [IW-1:0]       grant_idx_s;
    logic [ADDR_W-1:0]   rd_addr_sel_s;
    logic                timeout_hit_s;

    assign timeout_hit_s = (cnt_q == CW'(TIMEOUT - 1));

    // Pick the winning requester: lowest index in fixed mode, first eligible
    // index after last_grant in round-robin mode.
    always_comb begin
        int start_v;
        int idx_v;
        logic [IW-1:0] idx_s;
        elig_s      = write_override ? {wr_req, {N_RD{1'b0}}} : {wr_req, rd_req};
        grant_vld_s = 1'b0;
        grant_idx_s = {IW{1'b0}};
        start_v     = int'(last_grant_q) + 1;
        if (start_v >= NP) start_v = 0;
        else               start_v = start_v;
        for (int k = 0; k < NP; k++) begin
            if (mode_rr) idx_v = start_v + k;
            else         idx_v = k;
            if (idx_v >= NP) idx_v = idx_v - NP;
            else             idx_v = idx_v;
            idx_s = IW'(idx_v);
            if (!grant_vld_s && elig_s[idx_s]) begin
                grant_vld_s = 1'b1;
                grant_idx_s = idx_s;
            end else begin
                grant_vld_s = grant_vld_s;
            end
        end
    end

    // Extract the address of the candidate read port.
    always_comb begin
        rd_addr_sel_s = {ADDR_W{1'b0}};
        for (int k = 0; k < N_RD; k++) begin
            if (grant_idx_s == IW'(k)) rd_addr_sel_s = rd_addr[k*ADDR_W +: ADDR_W];
            else                       rd_addr_sel_s = rd_addr_sel_s;
        end
    end

    // State register with asynchronous reset.
    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic: ack finishes BUSY, timeout aborts it back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_s) state_d = S_BUSY;
                else             state_d = S_IDLE;
            end
            S_BUSY: begin
                if (avl_ack)            state_d = S_DONE;
                else if (timeout_hit_s) state_d = S_IDLE;
                else                    state_d = S_BUSY;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values; acks default low so they pulse one cycle.
    always_comb begin
        winner_d      = winner_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        avl_addr_d    = avl_addr_q;
        avl_wrdata_d  = avl_wrdata_q;
        avl_read_d    = avl_read_q;
        avl_write_d   = avl_write_q;
        rd_ack_d      = {N_RD{1'b0}};
        wr_ack_d      = 1'b0;
        rd_data_d     = rd_data_q;
        timeout_err_d = timeout_err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_vld_s) begin
                    winner_d     = grant_idx_s;
                    last_grant_d = grant_idx_s;
                    cnt_d        = {CW{1'b0}};
                    avl_wrdata_d = wr_data;
                    avl_write_d  = (grant_idx_s == IW'(N_RD));
                    avl_read_d   = (grant_idx_s != IW'(N_RD));
                    avl_addr_d   = (grant_idx_s == IW'(N_RD)) ? wr_addr : rd_addr_sel_s;
                end else begin
                    avl_read_d  = 1'b0;
                    avl_write_d = 1'b0;
                end
            end
            S_BUSY: begin
                if (avl_ack) begin
                    avl_read_d  = 1'b0;
                    avl_write_d = 1'b0;
                    wr_ack_d    = (winner_q == IW'(N_RD));
                    for (int k = 0; k < N_RD; k++) begin
                        rd_ack_d[k] = (winner_q == IW'(k));
                    end
                    if (winner_q != IW'(N_RD)) rd_data_d = avl_rddata;
                    else                       rd_data_d = rd_data_q;
                end else if (timeout_hit_s) begin
                    avl_read_d    = 1'b0;
                    avl_write_d   = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                avl_read_d  = 1'b0;
                avl_write_d = 1'b0;
            end
            default: begin
                avl_read_d  = 1'b0;
                avl_write_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; last_grant resets to the write port index.
    always_ff @(posedge MAX10_CLK1_50 or posedge Reset_h) begin
        if (Reset_h) begin
            winner_q      <= {IW{1'b0}};
            last_grant_q  <= IW'(N_RD);
            cnt_q         <= {CW{1'b0}};
            avl_addr_q    <= {ADDR_W{1'b0}};
            avl_wrdata_q  <= {DATA_W{1'b0}};
            avl_read_q    <= 1'b0;
            avl_write_q   <= 1'b0;
            rd_ack_q      <= {N_RD{1'b0}};
            wr_ack_q      <= 1'b0;
            rd_data_q     <= {DATA_W{1'b0}};
            timeout_err_q <= 1'b0;
        end else begin
            winner_q      <= winner_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            avl_addr_q    <= avl_addr_d;
            avl_wrdata_q  <= avl_wrdata_d;
            avl_read_q    <= avl_read_d;
            avl_write_q   <= avl_write_d;
            rd_ack_q      <= rd_ack_d;
            wr_ack_q      <= wr_ack_d;
            rd_data_q     <= rd_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign avl_addr    = avl_addr_q;
    assign avl_wrdata  = avl_wrdata_q;
    assign avl_read    = avl_read_q;
    assign avl_write   = avl_write_q;
    assign rd_ack      = rd_ack_q;
    assign wr_ack      = wr_ack_q;
    assign rd_data     = rd_data_q;
    assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_sdram_multiport_arbiter.sv
// Testbench for sdram_multiport_arbiter: table of grant scenarios, hand
// sequences for timeout/reset/stray-ack, and random traffic against a
// transaction-level arbitration model.
module tb_sdram_multiport_arbiter;
    logic        clk = 1'b0;
    logic        Reset_h;
    logic        mode_rr, write_override;
    logic [3:0]  rd_req;
    logic [25:0] rd_addr_a [4];
    logic [103:0] rd_addr;
    logic [3:0]  rd_ack;
    logic [15:0] rd_data;
    logic        wr_req;
    logic [25:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [25:0] avl_addr;
    logic        avl_read, avl_write;
    logic [15:0] avl_wrdata, avl_rddata;
    logic        avl_ack;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    assign rd_addr = {rd_addr_a[3], rd_addr_a[2], rd_addr_a[1], rd_addr_a[0]};

    always #5 clk = ~clk;

    sdram_multiport_arbiter #(.N_RD(4), .ADDR_W(26), .DATA_W(16), .TIMEOUT(15)) dut (
        .MAX10_CLK1_50(clk), .Reset_h(Reset_h), .mode_rr(mode_rr),
        .write_override(write_override), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_data(rd_data), .wr_req(wr_req), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_ack(wr_ack), .avl_addr(avl_addr), .avl_read(avl_read),
        .avl_write(avl_write), .avl_wrdata(avl_wrdata), .avl_rddata(avl_rddata),
        .avl_ack(avl_ack), .timeout_err(timeout_err)
    );

    typedef struct {
        bit         rr;
        bit         wo;
        logic [3:0] rq;
        bit         wq;
        int         w;     // expected winner, 4 = write port, -1 = none
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string nm);
        chk({nm, "_acks"}, {27'd0, rd_ack, wr_ack}, 32'd0);
        chk({nm, "_rdwr"}, {30'd0, avl_read, avl_write}, 32'd0);
        chk({nm, "_addr"}, {6'd0, avl_addr}, 32'd0);
        chk({nm, "_wrdata"}, {16'd0, avl_wrdata}, 32'd0);
        chk({nm, "_rddata"}, {16'd0, rd_data}, 32'd0);
        chk({nm, "_terr"}, {31'd0, timeout_err}, 32'd0);
    endtask

    // Arbitration rule: scan eligible indices in priority order, take the first.
    function automatic int model_pick(bit rr, bit wo, logic [3:0] rq, bit wq, int lg);
        int cand[$];
        int start = rr ? (lg + 1) % 5 : 0;
        for (int k = 0; k < 5; k++) begin
            int p = (start + k) % 5;
            bit e = (p == 4) ? wq : (!wo && (((rq >> p) & 4'd1) != 4'd0));
            if (e) cand.push_back(p);
        end
        return (cand.size() == 0) ? -1 : cand[0];
    endfunction

    // One full transfer starting in IDLE with requests already applied.
    task automatic run_xfer(input int w, input int lat, input bit disturb);
        logic [15:0] d;
        logic [3:0]  exp_ack;
        step();
        chk("issue_rd", {31'd0, avl_read}, {31'd0, (w < 4)});
        chk("issue_wr", {31'd0, avl_write}, {31'd0, (w == 4)});
        chk("issue_addr", {6'd0, avl_addr}, {6'd0, (w == 4) ? wr_addr : rd_addr_a[w]});
        if (w == 4) chk("issue_wrdata", {16'd0, avl_wrdata}, {16'd0, wr_data});
        if (disturb) begin
            mode_rr        = ~mode_rr;
            write_override = 1'($urandom_range(0, 1));
            if (w == 4) wr_req = 1'b0;
            else        rd_req = rd_req & ~(4'd1 << w);
        end
        for (int i = 1; i < lat; i++) begin
            step();
            chk("busy_hold", {30'd0, avl_read, avl_write}, {30'd0, (w < 4), (w == 4)});
            chk("busy_noack", {27'd0, rd_ack, wr_ack}, 32'd0);
        end
        d          = 16'($urandom);
        avl_rddata = d;
        avl_ack    = 1'b1;
        step();
        avl_ack = 1'b0;
        exp_ack = (w < 4) ? (4'd1 << w) : 4'd0;
        chk("done_rdack", {28'd0, rd_ack}, {28'd0, exp_ack});
        chk("done_wrack", {31'd0, wr_ack}, {31'd0, (w == 4)});
        chk("done_bus_off", {30'd0, avl_read, avl_write}, 32'd0);
        if (w < 4) chk("done_rddata", {16'd0, rd_data}, {16'd0, d});
        step();
        chk("ack_single", {27'd0, rd_ack, wr_ack}, 32'd0);
    endtask

    initial begin
        int n;
        bit saw_ack;
        int lg;
        logic [3:0] rq;
        bit wq;
        int w;

        Reset_h = 1'b1; mode_rr = 1'b0; write_override = 1'b0;
        rd_req = 4'd0; wr_req = 1'b0; avl_ack = 1'b0; avl_rddata = 16'd0;
        wr_addr = 26'h100; wr_data = 16'hBEEF;
        for (int k = 0; k < 4; k++) rd_addr_a[k] = 26'(32'h1000 * (k + 1) + k);

        tbl[0]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 0};
        tbl[1]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 1};
        tbl[2]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 2};
        tbl[3]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 3};
        tbl[4]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 4};
        tbl[5]  = '{1'b1, 1'b0, 4'b1111, 1'b1, 0};
        tbl[6]  = '{1'b0, 1'b0, 4'b0110, 1'b0, 1};
        tbl[7]  = '{1'b0, 1'b0, 4'b0110, 1'b0, 1};
        tbl[8]  = '{1'b0, 1'b0, 4'b0110, 1'b0, 1};
        tbl[9]  = '{1'b0, 1'b1, 4'b1111, 1'b1, 4};
        tbl[10] = '{1'b0, 1'b1, 4'b1111, 1'b0, -1};
        tbl[11] = '{1'b1, 1'b0, 4'b0110, 1'b0, 1};
        tbl[12] = '{1'b1, 1'b0, 4'b0110, 1'b0, 2};
        tbl[13] = '{1'b1, 1'b0, 4'b1001, 1'b1, 3};
        tbl[14] = '{1'b1, 1'b0, 4'b0001, 1'b0, 0};
        tbl[15] = '{1'b0, 1'b0, 4'b0000, 1'b1, 4};

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        Reset_h = 1'b0;
        step();

        // Table-driven grant scenarios, requests held, 2-cycle ack latency.
        for (int i = 0; i < 16; i++) begin
            mode_rr = tbl[i].rr; write_override = tbl[i].wo;
            rd_req = tbl[i].rq; wr_req = tbl[i].wq;
            if (tbl[i].w < 0) begin
                step();
                chk("tbl_no_issue", {30'd0, avl_read, avl_write}, 32'd0);
                step();
                chk("tbl_no_issue2", {30'd0, avl_read, avl_write}, 32'd0);
            end else begin
                run_xfer(tbl[i].w, 2, 1'b0);
            end
        end
        rd_req = 4'd0; wr_req = 1'b0; mode_rr = 1'b0; write_override = 1'b0;
        step();

        // Stray avl_ack in IDLE is ignored; a request still takes 1 cycle.
        avl_ack = 1'b1;
        step();
        chk("stray_ack_acks", {27'd0, rd_ack, wr_ack}, 32'd0);
        chk("stray_ack_bus", {30'd0, avl_read, avl_write}, 32'd0);
        step();
        avl_ack = 1'b0;
        chk("stray_ack_acks2", {27'd0, rd_ack, wr_ack}, 32'd0);
        rd_req = 4'b1000;
        run_xfer(3, 1, 1'b0);
        rd_req = 4'd0;

        // Timeout: no ack ever, read must drop after exactly 15 BUSY cycles.
        rd_req = 4'b0001;
        n = 0; saw_ack = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rd_ack != 4'd0) saw_ack = 1'b1;
            if (avl_read) n++;
            else break;
        end
        rd_req = 4'd0;
        chk("timeout_cycles", 32'(n), 32'd15);
        chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
        chk("timeout_no_ack", {31'd0, saw_ack}, 32'd0);
        step();
        chk("timeout_no_ack2", {28'd0, rd_ack}, 32'd0);
        rd_req = 4'b0010;
        run_xfer(1, 2, 1'b0);
        rd_req = 4'd0;
        chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset in the middle of BUSY aborts the transfer.
        rd_req = 4'b0100;
        step();
        chk("pre_reset_busy", {31'd0, avl_read}, 32'd1);
        Reset_h = 1'b1;
        #1;
        check_reset("midbusy_reset");
        rd_req = 4'd0;
        step();
        Reset_h = 1'b0;
        check_reset("after_reset");
        rd_req = 4'b0100;
        run_xfer(2, 3, 1'b0);
        rd_req = 4'd0;

        // Random traffic against the arbitration model; last_grant is N_RD
        // only because nothing has been granted in RR terms since... reset
        // again here so the model starts from a known point.
        Reset_h = 1'b1;
        step();
        Reset_h = 1'b0;
        lg = 4; rq = 4'd0; wq = 1'b0;
        for (int it = 0; it < 150; it++) begin
            rq = rq | (4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)));
            if ($urandom_range(0, 3) == 0) wq = 1'b1;
            mode_rr        = 1'($urandom_range(0, 1));
            write_override = ($urandom_range(0, 7) == 0);
            for (int k = 0; k < 4; k++) rd_addr_a[k] = 26'($urandom);
            wr_addr = 26'($urandom);
            wr_data = 16'($urandom);
            rd_req  = rq;
            wr_req  = wq;
            w = model_pick(mode_rr, write_override, rq, wq, lg);
            if (w < 0) begin
                step();
                chk("rand_no_issue", {30'd0, avl_read, avl_write}, 32'd0);
            end else begin
                run_xfer(w, int'($urandom_range(1, 4)), ($urandom_range(0, 3) == 0));
                lg = w;
                if (w == 4) wq = 1'b0;
                else        rq = rq & ~(4'd1 << w);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sdram_multiport_arbiter.md
SDRAM_MULTIPORT_ARBITER -- requirements
Module: sdram_multiport_arbiter

Interface
REQ-001 SHALL have parameter N_RD, default 4: number of read ports, range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 26: Avalon byte-address width.
REQ-003 SHALL have parameter DATA_W, default 16: data width.
REQ-004 SHALL have parameter TIMEOUT, default 1023: maximum wait cycles for an ack.
REQ-005 SHALL have port MAX10_CLK1_50, input, 1 bit: clock; reset is Reset_h, asynchronous, active-high.
REQ-006 SHALL have port Reset_h, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port mode_rr, input, 1 bit: 1 selects round-robin, 0 selects fixed priority.
REQ-008 SHALL have port write_override, input, 1 bit: when 1, only the write port is granted.
REQ-009 SHALL have port rd_req, input, N_RD bits: per-port read request, a level held until ack.
REQ-010 SHALL have port rd_addr, input, N_RD*ADDR_W bits: packed per-port addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rd_ack, output, N_RD bits: one-cycle completion pulse per port.
REQ-012 SHALL have port rd_data, output, DATA_W bits: registered read data, valid in the rd_ack cycle.
REQ-013 SHALL have ports wr_req (input, 1), wr_addr (input, ADDR_W), wr_data (input, DATA_W), and wr_ack (output, 1): the single write port.
REQ-014 SHALL have ports avl_addr (output, ADDR_W), avl_read (output, 1), avl_write (output, 1), avl_wrdata (output, DATA_W), avl_rddata (input, DATA_W), and avl_ack (input, 1): the bridge master.
REQ-015 SHALL have port timeout_err, output, 1 bit: sticky timeout flag.

Function
REQ-016 SHALL implement the FSM states IDLE, BUSY, and DONE.
REQ-017 In IDLE, with at least one eligible request, SHALL latch the winner index, address, and write data, and enter BUSY on the next edge.
REQ-018 Eligible requests: write_override=1 -> wr_req only; otherwise all rd_req bits plus wr_req, with the write port treated as index N_RD.
REQ-019 Fixed priority: lowest index wins, so read port 0 is highest and the write port is lowest.
REQ-020 Round-robin: search starts at (last_grant+1) mod (N_RD+1); last_grant resets to N_RD.
REQ-021 In BUSY, SHALL hold avl_addr/avl_wrdata constant and assert avl_read or avl_write until the cycle avl_ack=1.
REQ-022 On avl_ack in BUSY, SHALL deassert avl_read/avl_write on the next edge, register avl_rddata into rd_data for reads, and enter DONE.
REQ-023 In DONE, SHALL pulse rd_ack[winner] or wr_ack for exactly one cycle, then return to IDLE; minimum 3 cycles per transfer.
REQ-024 Request latency: from req seen in IDLE to avl_read/avl_write asserted SHALL be 1 cycle.
REQ-025 Requests are sampled only in IDLE; mode_rr and write_override changes SHALL NOT affect an in-flight transfer.
REQ-026 If a requester drops its req during BUSY, the transfer SHALL complete and the ack SHALL still pulse.
REQ-027 A BUSY wait counter SHALL count cycles; when it reaches TIMEOUT without ack, SHALL deassert the bus, set timeout_err, give no ack, and return to IDLE.
REQ-028 The wait counter SHALL be $clog2(TIMEOUT+1) bits wide and clear on entry to BUSY.
REQ-029 An avl_ack in IDLE or DONE SHALL be ignored.
REQ-030 At most one bit of rd_ack/wr_ack SHALL be high in any cycle.

Reset
REQ-031 Reset_h SHALL force IDLE, all acks 0, avl_read/avl_write 0, avl_addr/avl_wrdata/rd_data 0, timeout_err 0, counter 0, and last_grant=N_RD.
REQ-032 Reset_h asserted mid-BUSY SHALL abort the transfer immediately with no ack.
REQ-033 timeout_err SHALL be cleared only by reset.

Verification
REQ-034 Fixed mode, rd_req=4'b0110 held with 2-cycle ack latency -> grants port 1 repeatedly; port 2 is starved; rd_data equals avl_rddata at ack.
REQ-035 RR mode, rd_req=4'b1111 plus wr_req held -> grant order 0,1,2,3,W,0.
REQ-036 write_override=1, rd_req=4'b1111, wr_req=1, wr_addr=0x100, wr_data=0xBEEF -> only the write is issued; avl_write with 0x100/0xBEEF; wr_ack pulses once.
REQ-037 TIMEOUT=15, avl_ack held 0 -> avl_read drops after 15 BUSY cycles; timeout_err=1; no rd_ack.
REQ-038 Reset_h pulsed during BUSY -> next cycle all outputs at their reset values; a later request is served normally.
REQ-039 avl_ack pulsed in IDLE with no requests -> no ack pulse and the state stays IDLE.
